add_mul_pipe_rv: RTL and testbench
==================================

Name: add_mul_pipe_rv

Overview:
- Parametrised successor to the fixed 32-bit, free-running two-stage (x+y)*z stitched pipeline.
- Computes (x op y)*z, where op is add or subtract, selected per transaction.
- Adds a valid/ready handshake with full backpressure, per-stage valid tracking, a parametrised data width and an optional full-width product.
- Sits between a producer and a consumer; both use the standard valid/ready handshake.

Parameters:
WIDTH, 32, operand width in bits (>=1).
FULL_PRODUCT, 0, 0: out_data is the low WIDTH bits of the product; 1: out_data is the full 2*WIDTH-bit product.
OUT_W, derived (FULL_PRODUCT ? 2*WIDTH : WIDTH), not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  producer has a transaction.
in_ready  output  1  block accepts a transaction this cycle.
in_sub  input  1  0: sum = x+y; 1: sum = x-y.
x  input  WIDTH  operand.
y  input  WIDTH  operand.
z  input  WIDTH  multiplier.
out_valid  output  1  out_data holds a result.
out_ready  input  1  consumer accepts the result.
out_data  output  OUT_W  result.
busy  output  1  OR of all stage valid bits.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Three register stages, each with a valid bit:
  - p0: captures x, y, z, in_sub.
  - p1: holds sum (WIDTH bits, wraps mod 2^WIDTH) and z.
  - p2: holds the product.
- Arithmetic is unsigned throughout:
  - Subtract wraps: x-y mod 2^WIDTH.
  - Product = sum * z, full 2*WIDTH bits.
  - FULL_PRODUCT=0 truncates the product to its low WIDTH bits.
- Handshake:
  - Transfer occurs when valid && ready.
  - out_valid = p2 valid; out_data = p2 data.
- Stage advance rule (combinational ready chain):
  - r2 = !v2 | out_ready
  - r1 = !v1 | r2
  - r0 = !v0 | r1
  - in_ready = r0 & rst_n
- Per stage k, when rk is 1:
  - vk loads the upstream valid (in_valid for p0, v(k-1) for the others).
  - Data loads only when the upstream valid is 1; otherwise the data holds.
- When rk is 0, stage k holds its valid and data unchanged.
- Latency:
  - Input accepted in cycle N -> out_valid in cycle N+3, given no stall.
  - Throughput: 1 transaction per cycle when out_ready is held at 1.
- Ordering: strictly FIFO; no drop, no duplication.
- Backpressure:
  - With out_ready=0, the pipeline fills: up to 3 transactions held, then in_ready=0.
  - On release, results drain one per cycle.
  - in_ready reasserts in the same cycle that out_ready rises.
- Output stability: while out_valid=1 and out_ready=0, out_data is stable.
- Simultaneous pop and push on a full pipe: both occur; occupancy is unchanged.
- Reset (rst_n=0 at a rising edge):
  - All valid bits and data registers cleared to 0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready is 0 while rst_n=0.
- Reset mid-operation: in-flight transactions are discarded; no output is produced for them.
- First acceptance is possible in the first cycle with rst_n=1.
- busy = v0|v1|v2.

Test Plan:
- Reset then single transaction: x=3, y=4, z=5, in_sub=0 accepted in cycle 0 -> out_valid=1 in cycle 3 with out_data=35; busy=0 after the pop.
- Subtract wrap, WIDTH=32, FULL_PRODUCT=0: x=0, y=1, z=2 -> out_data=0xFFFFFFFE. Same stimulus with FULL_PRODUCT=1 -> 0x1_FFFFFFFE.
- Streaming with out_ready=1: 10 back-to-back inputs (x=i, y=1, z=2) -> outputs 2(i+1) on 10 consecutive cycles starting 3 cycles after the first accept; in_ready stays 1 throughout.
- Backpressure, out_ready=0 from cycle 0 with in_valid held: exactly 3 accepts, then in_ready=0 and out_data stable. Raise out_ready -> in_ready=1 the same cycle; results drain in order.
- Mid-operation reset: 2 transactions in flight, rst_n=0 for one edge -> out_valid=0, out_data=0, busy=0; no stale results appear afterward. in_ready=0 during reset and 1 after it.
- Random valid/ready throttling on both sides, 1000 transactions vs. a reference model -> all results match, in order, with no loss.

Source files
------------

// File: rtl/add_mul_pipe_rv.sv
// Three-stage (x +/- y) * z pipeline with valid/ready handshakes on both sides.
// Every stage tracks its own valid bit, so bubbles collapse under backpressure.
module add_mul_pipe_rv #(
  parameter int WIDTH        = 32,
  parameter int FULL_PRODUCT = 0,
  localparam int OUT_W       = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  logic             v0_q, v1_q, v2_q;
  logic [WIDTH-1:0] x_q, y_q, z0_q;
  logic             sub_q;
  logic [WIDTH-1:0] sum_q, z1_q;
  logic [OUT_W-1:0] prod_q;

  logic               r0, r1, r2;
  logic [WIDTH-1:0]   sum_d;
  logic [2*WIDTH-1:0] prod_full;
  logic [OUT_W-1:0]   prod_d;

  // A stage may load whenever it is empty or its successor can take its content.
  assign r2 = !v2_q | out_ready;
  assign r1 = !v1_q | r2;
  assign r0 = !v0_q | r1;

  assign sum_d     = sub_q ? (x_q - y_q) : (x_q + y_q);
  assign prod_full = {{WIDTH{1'b0}}, sum_q} * {{WIDTH{1'b0}}, z1_q};
  assign prod_d    = prod_full[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z0_q   <= '0;
      sub_q  <= 1'b0;
      sum_q  <= '0;
      z1_q   <= '0;
      prod_q <= '0;
    end else begin
      if (r0) begin
        v0_q <= in_valid;
        if (in_valid) begin
          x_q   <= x;
          y_q   <= y;
          z0_q  <= z;
          sub_q <= in_sub;
        end
      end
      if (r1) begin
        v1_q <= v0_q;
        if (v0_q) begin
          sum_q <= sum_d;
          z1_q  <= z0_q;
        end
      end
      if (r2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          prod_q <= prod_d;
        end
      end
    end
  end

  assign in_ready  = r0 & rst_n;
  assign out_valid = v2_q;
  assign out_data  = prod_q;
  assign busy      = v0_q | v1_q | v2_q;

endmodule

// File: tb/tb_add_mul_pipe_rv.sv
// Bench for add_mul_pipe_rv: truncated and full-product instances share one stimulus,
// checked against a transaction queue model plus directed literal expectations.
module tb_add_mul_pipe_rv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sub;
  logic [31:0] x, y, z;
  logic        out_ready;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out_data0;
  logic        in_ready1, out_valid1, busy1;
  logic [63:0] out_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_mul_pipe_rv #(.WIDTH(32), .FULL_PRODUCT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_sub(in_sub), .x(x), .y(y), .z(z), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  add_mul_pipe_rv #(.WIDTH(32), .FULL_PRODUCT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_sub(in_sub), .x(x), .y(y), .z(z), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] d0;
    logic [63:0] d1;
  } exp_t;

  exp_t q[$];
  int   pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] m, input logic s);
    logic [31:0] sum;
    sum = s ? (a - b) : (a + b);
    return {32'd0, sum} * {32'd0, m};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: the block is an in-order queue of at most 3 entries.
  logic        stall_prev = 1'b0;
  logic [31:0] prev0;
  logic [63:0] prev1;
  int          wait_cnt = 0;

  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (!rst_n) begin
      chk("in_ready_in_reset0", {63'd0, in_ready0}, 64'd0);
      chk("in_ready_in_reset1", {63'd0, in_ready1}, 64'd0);
      q.delete();
      stall_prev = 1'b0;
      wait_cnt   = 0;
    end else begin
      occ = q.size();
      chk("in_ready0", {63'd0, in_ready0}, {63'd0, (occ < 3) || out_ready});
      chk("in_ready1", {63'd0, in_ready1}, {63'd0, (occ < 3) || out_ready});
      chk("busy0", {63'd0, busy0}, {63'd0, occ > 0});
      chk("busy1", {63'd0, busy1}, {63'd0, occ > 0});
      if (occ == 0) begin
        chk("out_valid_empty0", {63'd0, out_valid0}, 64'd0);
        chk("out_valid_empty1", {63'd0, out_valid1}, 64'd0);
      end
      if (stall_prev) begin
        chk("held_valid0", {63'd0, out_valid0}, 64'd1);
        chk("held_valid1", {63'd0, out_valid1}, 64'd1);
        chk("held_data0", {32'd0, out_data0}, {32'd0, prev0});
        chk("held_data1", out_data1, prev1);
      end
      if (occ > 0) begin
        e = q[0];
        if (out_valid0) chk("head_data0", {32'd0, out_data0}, {32'd0, e.d0});
        if (out_valid1) chk("head_data1", out_data1, e.d1);
        if (out_valid0 && out_ready) begin
          void'(q.pop_front());
          pops++;
          $display("pop %0d: data0=0x%08h data1=0x%016h", pops, out_data0, out_data1);
        end
      end
      // With an empty path ahead of it the head can never take more than 3 cycles.
      if (occ > 0 && !out_valid0) wait_cnt++;
      else wait_cnt = 0;
      chk("head_latency_bound", {63'd0, wait_cnt <= 3}, 64'd1);
      if (in_valid && in_ready0) begin
        e.d1 = model(x, y, z, in_sub);
        e.d0 = e.d1[31:0];
        q.push_back(e);
      end
      stall_prev = out_valid0 && !out_ready;
      prev0 = out_data0;
      prev1 = out_data1;
    end
  end

  initial begin
    int   acc_count;
    logic acc;
    logic hold;
    int   sent;
    int   guard;

    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; z = '0;
    repeat (2) tick;

    // Single transaction accepted in the first cycle out of reset.
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; x = 3; y = 4; z = 5; in_sub = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_out_data0", {32'd0, out_data0}, 64'd0);
    chk("rst_out_data1", out_data1, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("first_in_ready", {63'd0, in_ready0}, 64'd1);
    tick; in_valid = 1'b0;
    @(negedge clk); chk("lat_c1", {63'd0, out_valid0}, 64'd0);
    tick; @(negedge clk); chk("lat_c2", {63'd0, out_valid0}, 64'd0);
    tick; @(negedge clk);
    chk("lat_c3_valid", {63'd0, out_valid0}, 64'd1);
    chk("single_data0", {32'd0, out_data0}, 64'd35);
    chk("single_data1", out_data1, 64'd35);
    tick; @(negedge clk);
    chk("single_busy_after", {63'd0, busy0}, 64'd0);

    // Subtract wrap.
    tick; in_valid = 1'b1; x = 0; y = 1; z = 2; in_sub = 1'b1;
    tick; in_valid = 1'b0; in_sub = 1'b0;
    tick; tick; @(negedge clk);
    chk("sub_valid", {63'd0, out_valid0}, 64'd1);
    chk("sub_wrap_data0", {32'd0, out_data0}, 64'h0000_0000_FFFF_FFFE);
    chk("sub_wrap_data1", out_data1, 64'h0000_0001_FFFF_FFFE);

    // Streaming: 10 back-to-back inputs, outputs on 10 consecutive cycles.
    tick;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 10); x = c; y = 1; z = 2;
      @(negedge clk);
      if (c < 10) chk("stream_in_ready", {63'd0, in_ready0}, 64'd1);
      if (c >= 3 && c < 13) begin
        chk("stream_valid", {63'd0, out_valid0}, 64'd1);
        chk("stream_data", {32'd0, out_data0}, 64'(2 * (c - 2)));
      end
      tick;
    end
    in_valid = 1'b0;

    // Backpressure: fill with out_ready low, then release with a push pending.
    out_ready = 1'b0; in_valid = 1'b1; x = 10; y = 0; z = 1;
    acc_count = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready0;
      tick;
      if (acc) begin acc_count++; x = x + 1; end
    end
    @(negedge clk);
    chk("bp_accepts", 64'(acc_count), 64'd3);
    chk("bp_in_ready_low", {63'd0, in_ready0}, 64'd0);
    chk("bp_held_data", {32'd0, out_data0}, 64'd10);
    tick; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("bp_drain0", {32'd0, out_data0}, 64'd10);
    tick; in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", {63'd0, out_valid0}, 64'd1);
      chk("bp_drain_data", {32'd0, out_data0}, 64'(10 + k));
      tick;
    end

    // Mid-operation reset with two transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1; x = 1; y = 1; z = 1;
    tick; x = 2;
    tick; in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy_before", {63'd0, busy0}, 64'd1);
    chk("mr_in_ready_low", {63'd0, in_ready0}, 64'd0);
    tick; rst_n = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("mr_out_data0", {32'd0, out_data0}, 64'd0);
    chk("mr_out_data1", out_data1, 64'd0);
    chk("mr_busy", {63'd0, busy0}, 64'd0);
    chk("mr_in_ready", {63'd0, in_ready0}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick; @(negedge clk);
      chk("mr_no_stale", {63'd0, out_valid0 | out_valid1}, 64'd0);
    end
    tick;

    // Random throttling on both sides against the queue model.
    sent = 0; guard = 0; hold = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 9) < 7);
        x = $urandom; y = $urandom; z = $urandom;
        in_sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready0) begin sent++; hold = 1'b0; end
      else hold = in_valid;
      tick;
      guard++;
    end
    chk("rand_all_sent", 64'(sent), 64'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick;
    @(negedge clk);
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_final_busy", {63'd0, busy0}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
